// File: rtl/conv_mac_seq_if.sv
// Handshake and operand bundle between conv_mac_seq and its neighbours (pair source,
// shared multiplier, result sink). The slave modport is the accumulator's view.
interface conv_mac_seq_if #(
    parameter int ACC_W = 24
);
    logic             start;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_pix;
    logic [7:0]       in_wgt;
    logic [7:0]       mult_a;
    logic [7:0]       mult_b;
    logic [15:0]      mult_m;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_pix;
    logic [ACC_W-1:0] out_acc;

    modport slave (
        input  start, in_valid, in_pix, in_wgt, mult_m, out_ready,
        output busy, in_ready, mult_a, mult_b, out_valid, out_pix, out_acc
    );

    modport master (
        output start, in_valid, in_pix, in_wgt, mult_m, out_ready,
        input  busy, in_ready, mult_a, mult_b, out_valid, out_pix, out_acc
    );
endinterface

// File: rtl/conv_mac_seq.sv
// Window sequencer/accumulator for the single-multiplier convolution datapath.
// Optional macro CONV_MAC_ROUND_EN: round-half-up before the output shift.
module conv_mac_seq #(
    parameter int KSIZE = 9,
    parameter int ACC_W = 24,
    parameter int FRAC  = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    conv_mac_seq_if.slave io
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [7:0]              LAST_TAP = 8'(KSIZE - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-128);
    localparam logic signed [ACC_W-1:0] BIAS     = (FRAC > 0) ? ACC_W'(1 << (FRAC - 1)) : '0;

    state_t                  state_q;
    logic [ACC_W-1:0]        acc_q;
    logic [7:0]              tap_cnt_q;
    logic                    out_valid_q;
    logic [7:0]              out_pix_q;
    logic [ACC_W-1:0]        out_acc_q;

    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;
    logic [7:0]              out_pix_d;

    function automatic logic [7:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return 8'h7F;
        else if (v < SAT_MIN) return 8'h80;
        else                  return v[7:0];
    endfunction

    // NOTE: every variable gets a value at the top of always_comb so no path can infer a latch.
    always_comb begin
        acc_d     = '0;
        biased    = '0;
        shifted   = '0;
        out_pix_d = '0;
        acc_d     = acc_q + {{(ACC_W-16){io.mult_m[15]}}, io.mult_m};
`ifdef CONV_MAC_ROUND_EN
        biased    = acc_d + BIAS;
`else
        biased    = acc_d;
`endif
        shifted   = biased >>> FRAC;
        out_pix_d = saturate(shifted);
    end

    // The multiplier is combinational, so operands pass straight through in every state.
    assign io.mult_a    = io.in_pix;
    assign io.mult_b    = io.in_wgt;
    assign io.in_ready  = (state_q == ACCUM);
    assign io.busy      = (state_q != IDLE);
    assign io.out_valid = out_valid_q;
    assign io.out_pix   = out_pix_q;
    assign io.out_acc   = out_acc_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tap_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_acc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.start) begin
                        state_q   <= ACCUM;
                        acc_q     <= '0;
                        tap_cnt_q <= '0;
                    end
                end
                ACCUM: begin
                    if (io.in_valid) begin
                        acc_q     <= acc_d;
                        tap_cnt_q <= tap_cnt_q + 8'd1;
                        if (tap_cnt_q == LAST_TAP) begin
                            state_q     <= DONE;
                            out_acc_q   <= acc_d;
                            out_pix_q   <= out_pix_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed bench for conv_mac_seq: windows of hand-picked products with known sums,
// stalls on both sides, mid-window reset and ignored start pulses.
module tb_conv_mac_seq;
    localparam int KSIZE = 9;
    localparam int ACC_W = 24;
    localparam int FRAC  = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] taps [KSIZE];

    conv_mac_seq_if #(.ACC_W(ACC_W)) bus ();

    conv_mac_seq #(.KSIZE(KSIZE), .ACC_W(ACC_W), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acc32(input logic [ACC_W-1:0] a);
        return {{(32-ACC_W){a[ACC_W-1]}}, a};
    endfunction

    task automatic fill(input logic [15:0] first, input logic [15:0] rest);
        taps[0] = first;
        for (int i = 1; i < KSIZE; i++) taps[i] = rest;
    endtask

    // mode 0: contiguous taps, 1: one idle cycle between taps, 2: start pulse mid-window
    task automatic run_window(input string tag, input int mode, input int exp_acc,
                              input logic [7:0] exp_pix);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < KSIZE; i++) begin
            if (mode == 2 && i == 4) begin
                bus.in_valid = 1'b0;
                bus.mult_m   = 16'h7FFF;
                bus.start    = 1'b1;
                @(negedge clk);
                bus.start    = 1'b0;
            end
            bus.in_valid = 1'b1;
            bus.mult_m   = taps[i];
            bus.in_pix   = 8'(i * 7 + 3);
            bus.in_wgt   = 8'(8'h80 - i);
            if (i == KSIZE - 1) begin
                check({tag, "_ov_early"}, 32'(bus.out_valid), 32'd0);
                check({tag, "_mult_a"}, 32'(bus.mult_a), 32'(8'(i * 7 + 3)));
                check({tag, "_mult_b"}, 32'(bus.mult_b), 32'(8'(8'h80 - i)));
            end
            @(negedge clk);
            if (mode == 1 && i < KSIZE - 1) begin
                bus.in_valid = 1'b0;
                bus.mult_m   = 16'h7FFF;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        check({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_acc"}, acc32(bus.out_acc), 32'(exp_acc));
        check({tag, "_pix"}, 32'(bus.out_pix), 32'(exp_pix));
        check({tag, "_ready_done"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic finish_window(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pix    = '0;
        bus.in_wgt    = '0;
        bus.mult_m    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ov", 32'(bus.out_valid), 32'd0);
        check("rst_pix", 32'(bus.out_pix), 32'd0);
        check("rst_acc", acc32(bus.out_acc), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // in_valid in IDLE must not be accepted
        bus.in_valid = 1'b1;
        bus.mult_m   = 16'd100;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.in_ready), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end
        bus.in_valid = 1'b0;

        fill(16'd128, 16'd128);
        run_window("basic", 0, 1152, 8'd9);
        finish_window("basic");

        fill(16'h4000, 16'h4000);
        run_window("sat_pos", 0, 147456, 8'h7F);
        finish_window("sat_pos");

        fill(16'hC000, 16'hC000);
        run_window("sat_neg", 0, -147456, 8'h80);
        finish_window("sat_neg");

        fill(16'd128, 16'd128);
        run_window("gaps", 1, 1152, 8'd9);
        finish_window("gaps");

        fill(16'd128, 16'd128);
        run_window("mid_start", 2, 1152, 8'd9);
        finish_window("mid_start");

        // Output stall: result held, start ignored, including in the handshake cycle
        fill(16'd128, 16'd128);
        run_window("ostall", 0, 1152, 8'd9);
        for (int c = 0; c < 5; c++) begin
            bus.start = (c == 2);
            @(negedge clk);
            bus.start = 1'b0;
            check("ostall_ov", 32'(bus.out_valid), 32'd1);
            check("ostall_pix", 32'(bus.out_pix), 32'd9);
        end
        bus.start = 1'b1;
        finish_window("ostall");
        bus.start = 1'b0;
        @(negedge clk);
        check("ostall_no_restart", 32'(bus.busy), 32'd0);

`ifdef CONV_MAC_ROUND_EN
        fill(16'd192, 16'd0);
        run_window("rnd_192", 0, 192, 8'd2);
        finish_window("rnd_192");
        fill(16'hFFC0, 16'd0);
        run_window("rnd_m64", 0, -64, 8'd0);
        finish_window("rnd_m64");
        fill(16'd63, 16'd0);
        run_window("rnd_63", 0, 63, 8'd0);
        finish_window("rnd_63");
        fill(16'h4000, 16'h4000);
        run_window("rnd_sat", 0, 147456, 8'h7F);
        finish_window("rnd_sat");
`else
        fill(16'd192, 16'd0);
        run_window("trunc_192", 0, 192, 8'd1);
        finish_window("trunc_192");
        fill(16'hFFC0, 16'd0);
        run_window("trunc_m64", 0, -64, 8'hFF);
        finish_window("trunc_m64");
        fill(16'd63, 16'd0);
        run_window("trunc_63", 0, 63, 8'd0);
        finish_window("trunc_63");
`endif

        // Leave a non-zero result registered, then abort a window with reset
        fill(16'h4000, 16'h4000);
        run_window("pre_rst", 0, 147456, 8'h7F);
        finish_window("pre_rst");
        fill(16'h0100, 16'h0100);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.mult_m   = 16'h0100;
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_ov", 32'(bus.out_valid), 32'd0);
        check("arst_acc", acc32(bus.out_acc), 32'd0);
        check("arst_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill(16'd128, 16'd128);
        run_window("post_rst", 0, 1152, 8'd9);
        finish_window("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
